// File: rtl/prog_func_lut_if.sv
// Bundle between prog_func_lut and its user: the evaluate path, the counter
// clear and the serial table-load port.
interface prog_func_lut_if #(
  parameter int N     = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [N-1:0]     in;
  logic             f;
  logic             out_valid;
  logic             f_chg;
  logic [CNT_W-1:0] ones_cnt;
  logic             cnt_clr;
  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_busy;
  logic             cfg_done;

  modport master (
    output in_valid, in, cnt_clr, cfg_start, cfg_valid, cfg_bit,
    input  f, out_valid, f_chg, ones_cnt, cfg_busy, cfg_done
  );

  modport slave (
    input  in_valid, in, cnt_clr, cfg_start, cfg_valid, cfg_bit,
    output f, out_valid, f_chg, ones_cnt, cfg_busy, cfg_done
  );
endinterface

// File: rtl/prog_func_lut.sv
// Registered N-input boolean function from a 2^N-entry truth table, with a
// serially loaded shadow table that is committed atomically.
module prog_func_lut #(
  parameter int                N     = 5,
  parameter int                CNT_W = 8,
  parameter logic [(1<<N)-1:0] INIT  = {{((1 << N) - 1){1'b1}}, 1'b0}
) (
  input logic            clk,
  input logic            rst,
  prog_func_lut_if.slave bus
);
  localparam int TBL = 1 << N;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state_q, state_d;
  logic [TBL-1:0]   active_q, shadow_q, shadow_d;
  logic [N:0]       bit_cnt_q;
  logic             wr_en, last_wr, done_q, busy;

  logic             f_q, vld_q, chg_q, f_new;
  logic [CNT_W-1:0] cnt_q;

  // ---------------- config FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- config FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.cfg_start) state_d = LOAD;
      LOAD: begin
        if (bus.cfg_start)  state_d = LOAD;
        else if (last_wr)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- config FSM: outputs ----------------
  // A restart in the same cycle as a data bit drops that bit.
  always_comb begin
    busy     = (state_q == LOAD);
    wr_en    = busy && bus.cfg_valid && !bus.cfg_start;
    last_wr  = wr_en && (bit_cnt_q == (N+1)'(TBL - 1));
    shadow_d = shadow_q;
    if (wr_en) shadow_d[bit_cnt_q[N-1:0]] = bus.cfg_bit;
  end

  // The counter is one bit wider than the index so TBL-1 is seen before wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shadow_q  <= INIT;
      active_q  <= INIT;
      done_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      done_q   <= last_wr;
      if (bus.cfg_start || last_wr) bit_cnt_q <= '0;
      else if (wr_en)               bit_cnt_q <= bit_cnt_q + (N+1)'(1);
      // Commit includes the final bit arriving this cycle.
      if (last_wr) active_q <= shadow_d;
    end
  end

  // ---------------- evaluation path ----------------
  // f only moves on valid results, so f_q doubles as the previous valid f.
  assign f_new = active_q[bus.in];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q   <= 1'b0;
      vld_q <= 1'b0;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= bus.in_valid;
      chg_q <= bus.in_valid && (f_new != f_q);
      if (bus.in_valid) f_q <= f_new;
      if (bus.cnt_clr)
        cnt_q <= '0;
      else if (bus.in_valid && f_new && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.f         = f_q;
  assign bus.out_valid = vld_q;
  assign bus.f_chg     = chg_q;
  assign bus.ones_cnt  = cnt_q;
  assign bus.cfg_busy  = busy;
  assign bus.cfg_done  = done_q;
endmodule
